mem_stage_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle memory stage. It resolves next-PC selection (sequential, branch target or ALU jump) and performs loads and stores against a variable-latency memory over a req/ack handshake. It raises a stall to the pipeline while an access is outstanding and reports a sticky error on memory timeout. It sits between execute and writeback and replaces the direct memory instance.

---
 rtl/mem_stage_mc_if.sv | 39 +++
 rtl/mem_stage_mc.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage_mc.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_mc_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage_mc_if
// Request/acknowledge memory bus between the memory stage and a
// variable-latency memory.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
interface mem_stage_mc_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  // Stage side: issues requests, receives read data and completion
  modport master (
    output mem_req,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  // Memory side
  modport slave (
    input  mem_req,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage_mc
// Multi-cycle memory stage: next-PC selection plus loads/stores against a
// variable-latency memory over req/ack, with pipeline stall, halt/dump and a
// sticky timeout error.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module mem_stage_mc #(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int MAX_WAIT = 15
) (
  input  wire           clk,
  input  wire           rst,
  input  wire           valid_in,
  input  wire           rd_en,
  input  wire           wr_en,
  input  wire           halt,
  input  wire  [AW-1:0] addr,
  input  wire  [DW-1:0] data_in,
  input  wire  [AW-1:0] in_pc,
  input  wire  [AW-1:0] adder_src,
  input  wire           brch_cnd,
  input  wire           alu_jmp,
  mem_stage_mc_if.master mem_bus,
  output logic          mem_dump,
  output logic          stall,
  output logic          valid_out,
  output logic [DW-1:0] data_out,
  output logic [AW-1:0] out_pc,
  output logic          err
);

  // Counter must be able to hold MAX_WAIT itself
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] C_LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halted_q, halted_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          valid_out_q, valid_out_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic [AW-1:0] out_pc_q, out_pc_d;
  logic          dump_q, dump_d;
  logic          stall_w;

  logic [AW-1:0] next_pc_w;
  logic          access_w;

  // Next-PC select: register jump wins over a taken branch; sum wraps
  always_comb begin
    next_pc_w = in_pc;
    if (alu_jmp) begin
      next_pc_w = addr;
    end else if (brch_cnd) begin
      next_pc_w = in_pc + adder_src;
    end
  end

  // A halt takes precedence, so a halt carrying rd_en/wr_en never touches memory
  assign access_w = valid_in & (rd_en | wr_en) & ~halted_q & ~halt;

  // State register and all registered results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      out_pc_q    <= '0;
      dump_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halted_q    <= halted_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pc_q        <= pc_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      out_pc_q    <= out_pc_d;
      dump_q      <= dump_d;
    end
  end

  // Next-state and stall decode; mem_rdata only reaches data_out_d
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    halted_d    = halted_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pc_d        = pc_q;
    valid_out_d = 1'b0;
    data_out_d  = data_out_q;
    out_pc_d    = out_pc_q;
    dump_d      = 1'b0;
    stall_w     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_in && !halted_q) begin
          if (halt) begin
            halted_d    = 1'b1;
            dump_d      = 1'b1;
            valid_out_d = 1'b1;
            out_pc_d    = in_pc;
          end else if (access_w) begin
            wr_d    = wr_en;
            addr_d  = addr;
            wdata_d = data_in;
            pc_d    = next_pc_w;
            cnt_d   = '0;
            stall_w = 1'b1;
            state_d = S_BUSY;
          end else begin
            valid_out_d = 1'b1;
            out_pc_d    = next_pc_w;
          end
        end
      end
      S_BUSY: begin
        stall_w = 1'b1;
        if (mem_bus.mem_ack) begin
          if (!wr_q) begin
            data_out_d = mem_bus.mem_rdata;
          end
          cnt_d       = '0;
          valid_out_d = 1'b1;
          out_pc_d    = pc_q;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == C_LAST_WAIT) begin
            state_d = S_ERR;
          end
        end
      end
      S_DONE: begin
        // Instruction still at the inputs was the one just serviced
        state_d = S_IDLE;
      end
      S_ERR: begin
        stall_w = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_bus.mem_req   = (state_q == S_BUSY);
  assign mem_bus.mem_wr    = (state_q == S_BUSY) & wr_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_wdata = wdata_q;

  assign mem_dump  = dump_q;
  assign stall     = stall_w;
  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign out_pc    = out_pc_q;
  assign err       = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_stage_mc
// Self-checking bench for mem_stage_mc against a transaction-level model.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_mem_stage_mc;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MAX_WAIT = 4;

  logic          clk;
  logic          rst;
  logic          valid_in, rd_en, wr_en, halt, brch_cnd, alu_jmp;
  logic [AW-1:0] addr, in_pc, adder_src;
  logic [DW-1:0] data_in;
  logic          mem_dump, stall, valid_out, err;
  logic [DW-1:0] data_out;
  logic [AW-1:0] out_pc;

  int n_vec;
  int n_err;
  logic [DW-1:0] exp_dout;

  mem_stage_mc_if #(.DW(DW), .AW(AW)) mbus ();

  mem_stage_mc #(.DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .halt      (halt),
    .addr      (addr),
    .data_in   (data_in),
    .in_pc     (in_pc),
    .adder_src (adder_src),
    .brch_cnd  (brch_cnd),
    .alu_jmp   (alu_jmp),
    .mem_bus   (mbus),
    .mem_dump  (mem_dump),
    .stall     (stall),
    .valid_out (valid_out),
    .data_out  (data_out),
    .out_pc    (out_pc),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference next PC: plain integer arithmetic modulo 2^AW
  function automatic logic [AW-1:0] ref_pc(input logic jmp, input logic br,
                                           input logic [AW-1:0] a, input logic [AW-1:0] pc,
                                           input logic [AW-1:0] off);
    int unsigned s;
    if (jmp) return a;
    if (br) begin
      s = (int'(pc) + int'(off)) % 65536;
      return AW'(s);
    end
    return pc;
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0; rd_en = 1'b0; wr_en = 1'b0; halt = 1'b0;
    brch_cnd = 1'b0; alu_jmp = 1'b0;
  endtask

  // One instruction from issue to completion; starts and ends at posedge+1
  task automatic run_op(input logic rd, input logic wr, input logic br, input logic jmp,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [AW-1:0] pc, input logic [AW-1:0] off,
                        input int k, input logic [DW-1:0] rdata);
    logic [AW-1:0] epc;
    logic is_acc;
    epc = ref_pc(jmp, br, a, pc, off);
    is_acc = rd | wr;
    valid_in = 1'b1; rd_en = rd; wr_en = wr; halt = 1'b0;
    brch_cnd = br; alu_jmp = jmp; addr = a; data_in = d; in_pc = pc; adder_src = off;
    mbus.mem_ack = 1'b0;
    @(negedge clk);
    check_eq("issue_stall", stall, is_acc);
    check_eq("issue_req", mbus.mem_req, 1'b0);
    if (is_acc) begin
      for (int i = 0; i <= k; i++) begin
        @(posedge clk); #1;
        mbus.mem_ack = (i == k);
        mbus.mem_rdata = (i == k) ? rdata : DW'($urandom);
        @(negedge clk);
        check_eq("busy_req", mbus.mem_req, 1'b1);
        check_eq("busy_wr", mbus.mem_wr, wr);
        check_eq("busy_addr", mbus.mem_addr, a);
        if (wr) check_eq("busy_wdata", mbus.mem_wdata, d);
        check_eq("busy_stall", stall, 1'b1);
        check_eq("busy_vout", valid_out, 1'b0);
      end
      @(posedge clk); #1;
      mbus.mem_ack = 1'b0;
      mbus.mem_rdata = DW'($urandom);
      if (!wr) exp_dout = rdata;
      @(negedge clk);
      check_eq("done_vout", valid_out, 1'b1);
      check_eq("done_pc", out_pc, epc);
      check_eq("done_dout", data_out, exp_dout);
      check_eq("done_stall", stall, 1'b0);
      check_eq("done_req", mbus.mem_req, 1'b0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check_eq("post_vout", valid_out, 1'b0);
      check_eq("post_req", mbus.mem_req, 1'b0);
    end else begin
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check_eq("alu_vout", valid_out, 1'b1);
      check_eq("alu_pc", out_pc, epc);
      check_eq("alu_dout", data_out, exp_dout);
      check_eq("alu_stall", stall, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    mbus.mem_ack = 1'b0;
    exp_dout = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    addr = '0; data_in = '0; in_pc = '0; adder_src = '0;
    mbus.mem_ack = 1'b0;
    mbus.mem_rdata = '0;
    do_reset();
    @(negedge clk);
    check_eq("rst_vout", valid_out, 1'b0);
    check_eq("rst_req", mbus.mem_req, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_pc", out_pc, 16'h0000);
    check_eq("rst_dout", data_out, 16'h0000);
    check_eq("rst_dump", mem_dump, 1'b0);
    @(posedge clk); #1;

    // Directed: load with 3 waits, zero-wait store, PC selection
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0102, 16'h0000, 3, 16'hBEEF);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, 16'h0104, 16'h0000, 0, 16'h5A5A);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h7777, 16'h0106, 16'h0000, 1, 16'h9999);
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFE, 16'h0004, 0, 16'h0000);
    run_op(1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 16'h0000, 16'hFFFE, 16'h0004, 0, 16'h0000);

    // Randomized instruction mix
    for (int n = 0; n < 40; n++) begin
      run_op(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
             AW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom),
             int'($urandom_range(0, MAX_WAIT - 1)), DW'($urandom));
    end

    // Reset while an access is outstanding
    valid_in = 1'b1; rd_en = 1'b1; addr = 16'h0300; in_pc = 16'h0010;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rb_req", mbus.mem_req, 1'b1);
    #2;
    rst = 1'b0;
    idle_inputs();
    exp_dout = '0;
    #1;
    check_eq("rb_req0", mbus.mem_req, 1'b0);
    check_eq("rb_stall0", stall, 1'b0);
    check_eq("rb_vout0", valid_out, 1'b0);
    check_eq("rb_err0", err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    mbus.mem_ack = 1'b1;
    mbus.mem_rdata = 16'hDEAD;
    @(negedge clk);
    check_eq("rb_req1", mbus.mem_req, 1'b0);
    @(posedge clk); #1;
    mbus.mem_ack = 1'b0;
    @(negedge clk);
    check_eq("rb_vout1", valid_out, 1'b0);
    check_eq("rb_dout1", data_out, 16'h0000);
    @(posedge clk); #1;

    // Timeout: load never acknowledged
    valid_in = 1'b1; rd_en = 1'b1; addr = 16'h0400; in_pc = 16'h0020;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("to_busy_req", mbus.mem_req, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mbus.mem_ack = (i == 1);
      @(negedge clk);
      check_eq("to_err", err, 1'b1);
      check_eq("to_req", mbus.mem_req, 1'b0);
      check_eq("to_stall", stall, 1'b1);
      check_eq("to_vout", valid_out, 1'b0);
    end
    @(posedge clk); #1;
    do_reset();

    // Halt carrying a load request
    valid_in = 1'b1; halt = 1'b1; rd_en = 1'b1; in_pc = 16'h0ABC; addr = 16'h0500;
    @(negedge clk);
    check_eq("h_req0", mbus.mem_req, 1'b0);
    check_eq("h_dump0", mem_dump, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_eq("h_dump1", mem_dump, 1'b1);
    check_eq("h_vout1", valid_out, 1'b1);
    check_eq("h_pc1", out_pc, 16'h0ABC);
    check_eq("h_req1", mbus.mem_req, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1; rd_en = 1'($urandom); wr_en = 1'($urandom); halt = (i == 2);
      @(negedge clk);
      check_eq("hd_dump", mem_dump, 1'b0);
      check_eq("hd_vout", valid_out, 1'b0);
      check_eq("hd_req", mbus.mem_req, 1'b0);
      check_eq("hd_stall", stall, 1'b0);
    end
    @(posedge clk); #1;
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
